// File: rtl/stream_sink_checker_if.sv
// Ready/valid stream carrying one beat of WIDTH bits.
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both 1; the master holds bits stable while valid is 1 and ready is 0.
interface stream_sink_checker_if #(
  parameter int WIDTH = 32
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] bits;

  modport master (output valid, output bits, input ready);
  modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/stream_sink_checker.sv
// Receive end of the offload stream: applies a periodic backpressure pattern,
// checks each accepted beat against base + i*step and reports a run verdict.
module stream_sink_checker #(
  parameter int               WIDTH     = 32,
  parameter int               EXP_COUNT = 51,
  parameter logic [WIDTH-1:0] EXP_BASE  = WIDTH'(2),
  parameter logic [WIDTH-1:0] EXP_STEP  = '0,
  parameter int               BP_PERIOD = 4,
  parameter int               TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  stream_sink_checker_if.slave    io_in,
  output logic [15:0]             count,
  output logic [15:0]             err_count,
  output logic [15:0]             first_err_idx,
  output logic [WIDTH-1:0]        first_err_data,
  output logic                    done,
  output logic                    timed_out,
  output logic                    pass,
  output logic [1:0]              state_dbg
);

  localparam int BPW = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;
  localparam logic [BPW-1:0] BP_LAST = (BP_PERIOD > 0) ? BPW'(BP_PERIOD - 1) : '0;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [15:0] LAST_IDX = 16'(EXP_COUNT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BPW-1:0]   bp_cnt_q, bp_cnt_d;
  logic [TW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             ready_q, ready_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [15:0]      first_err_idx_q, first_err_idx_d;
  logic [WIDTH-1:0] first_err_data_q, first_err_data_d;
  logic             pass_q, pass_d;
  logic             accept;

  // Next-state logic: acceptance, checking, backpressure phase and run FSM.
  always_comb begin
    state_d          = state_q;
    bp_cnt_d         = bp_cnt_q;
    idle_cnt_d       = idle_cnt_q;
    exp_d            = exp_q;
    count_d          = count_q;
    err_count_d      = err_count_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    accept           = io_in.valid & ready_q;

    // Beat counter is common to every state and saturates.
    if (accept && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end

    case (state_q)
      ST_RUN: begin
        // Backpressure phase advances every RUN cycle regardless of traffic.
        if (BP_PERIOD == 0 || bp_cnt_q == BP_LAST) begin
          bp_cnt_d = '0;
        end else begin
          bp_cnt_d = bp_cnt_q + BPW'(1);
        end
        if (accept) begin
          idle_cnt_d = '0;
          exp_d      = exp_q + EXP_STEP;
          if (io_in.bits != exp_q) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            if (err_count_q == 16'd0) begin
              first_err_idx_d  = count_q;
              first_err_data_d = io_in.bits;
            end
          end
          if (count_q == LAST_IDX) state_d = ST_DONE;
        end else if (TIMEOUT != 0) begin
          // An accept in the same cycle takes priority over the timeout.
          if (idle_cnt_q == TO_LAST) begin
            state_d = ST_TIMEOUT;
          end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
          end
        end
      end
      ST_DONE: begin
        // Any beat after the expected run is an error; data is not compared.
        if (accept) begin
          if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          if (err_count_q == 16'd0) begin
            first_err_idx_d  = count_q;
            first_err_data_d = io_in.bits;
          end
        end
      end
      default: begin
      end
    endcase

    // Ready is held high outside RUN so an upstream source can always drain.
    ready_d = (state_d != ST_RUN) || !(BP_PERIOD != 0 && bp_cnt_d == BP_LAST);
    pass_d  = (state_d == ST_DONE) && (err_count_d == 16'd0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ST_RUN;
      bp_cnt_q         <= '0;
      idle_cnt_q       <= '0;
      exp_q            <= EXP_BASE;
      ready_q          <= (BP_PERIOD != 1);
      count_q          <= '0;
      err_count_q      <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      bp_cnt_q         <= bp_cnt_d;
      idle_cnt_q       <= idle_cnt_d;
      exp_q            <= exp_d;
      ready_q          <= ready_d;
      count_q          <= count_d;
      err_count_q      <= err_count_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      pass_q           <= pass_d;
    end
  end

  assign io_in.ready    = ready_q;
  assign count          = count_q;
  assign err_count      = err_count_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;
  assign done           = (state_q != ST_RUN);
  assign timed_out      = (state_q == ST_TIMEOUT);
  assign pass           = pass_q;
  assign state_dbg      = state_q;

endmodule
